// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM/owner types and default bus widths for the memory arbiter
package mem_arbiter_pkg;
   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {OWN_IFU, OWN_LSU} owner_t;
endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational winner selection between fetch and load/store requesters
//   i_ifu_valid / i_lsu_valid  requester valids
//   i_starve                   consecutive IFU losses so far
//   o_ifu_win / o_lsu_win      one-hot (or zero) winner; a win implies the matching valid
module arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic             i_ifu_valid,
   input  logic             i_lsu_valid,
   input  logic [CNT_W-1:0] i_starve,
   output logic             o_ifu_win,
   output logic             o_lsu_win
);
   logic w_starved;
   assign w_starved = (i_starve == CNT_W'(STARVE_MAX));
   // LSU has priority until the IFU has lost STARVE_MAX times in a row
   assign o_ifu_win = i_ifu_valid && (!i_lsu_valid || w_starved);
   assign o_lsu_win = i_lsu_valid && !(i_ifu_valid && w_starved);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter sharing one memory port between IFU and LSU
//   clk, rst                         clock, asynchronous active-high reset
//   ifu_req_*/ifu_addr               fetch request (always a read)
//   ifu_resp_valid/ifu_rdata         one-cycle fetch response, data held until next response
//   lsu_req_*/lsu_addr/lsu_wen/...   load/store request
//   lsu_resp_valid/lsu_rdata         one-cycle load/store response (data 0 for stores)
//   mem_ren/mem_wen/mem_*            one-cycle memory strobe with latched payload
//   mem_resp_valid/mem_rdata         memory completion
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   state_t            r_state, w_next;
   owner_t            r_owner;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wen;
   logic [DATA_W-1:0] r_wdata, r_ifu_rdata, r_lsu_rdata;
   logic [7:0]        r_wmask;
   logic [CNT_W-1:0]  r_starve;
   logic              w_arb, w_ifu_win, w_lsu_win, w_ifu_hs, w_lsu_hs, w_mem_done;
   arb_pick #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_pick (
      .i_ifu_valid(ifu_req_valid),
      .i_lsu_valid(lsu_req_valid),
      .i_starve   (r_starve),
      .o_ifu_win  (w_ifu_win),
      .o_lsu_win  (w_lsu_win)
   );
   always_comb begin
      // rst gates the ready outputs so they drop the instant reset is asserted
      w_arb      = !rst && (r_state == IDLE || r_state == RESP);
      w_ifu_hs   = w_arb && w_ifu_win;
      w_lsu_hs   = w_arb && w_lsu_win;
      w_mem_done = (r_state == ISSUE || r_state == WAIT) && mem_resp_valid;
      w_next     = w_arb || r_state == IDLE || r_state == RESP
                 ? ((w_ifu_hs || w_lsu_hs) ? ISSUE : IDLE)
                 : (mem_resp_valid ? RESP : WAIT);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= OWN_IFU;
         r_addr      <= '0;
         r_wen       <= 1'b0;
         r_wdata     <= '0;
         r_wmask     <= '0;
         r_starve    <= '0;
         r_ifu_rdata <= '0;
         r_lsu_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_ifu_hs) begin
            r_owner  <= OWN_IFU;
            r_addr   <= ifu_addr;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_starve <= '0;
         end else if (w_lsu_hs) begin
            r_owner <= OWN_LSU;
            r_addr  <= lsu_addr;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_wmask <= lsu_wmask;
            if (ifu_req_valid && r_starve != CNT_W'(STARVE_MAX))
               r_starve <= r_starve + 1'b1;
         end
         if (w_mem_done && r_owner == OWN_IFU)
            r_ifu_rdata <= mem_rdata;
         if (w_mem_done && r_owner == OWN_LSU)
            r_lsu_rdata <= r_wen ? '0 : mem_rdata;
      end
   end
   assign ifu_req_ready  = w_ifu_hs;
   assign lsu_req_ready  = w_lsu_hs;
   assign mem_ren        = r_state == ISSUE && !r_wen;
   assign mem_wen        = r_state == ISSUE && r_wen;
   assign mem_addr       = r_addr;
   assign mem_wdata      = r_wdata;
   assign mem_wmask      = r_wmask;
   assign ifu_resp_valid = r_state == RESP && r_owner == OWN_IFU;
   assign lsu_resp_valid = r_state == RESP && r_owner == OWN_LSU;
   assign ifu_rdata      = r_ifu_rdata;
   assign lsu_rdata      = r_lsu_rdata;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 64, address width.
REQ-002 SHALL have parameter DATA_W, 64, data width.
REQ-003 SHALL have parameter STARVE_MAX, 4, max consecutive IFU losses before IFU is forced to win (>=1).
REQ-004 SHALL have ports, one clock, reset asynchronous active-high:
  clk  in  1  clock, all state on rising edge
  rst  in  1  asynchronous active-high reset
  ifu_req_valid  in  1  fetch request
  ifu_req_ready  out  1  fetch request accepted this cycle
  ifu_addr  in  ADDR_W  fetch address
  ifu_resp_valid  out  1  one-cycle fetch response strobe
  ifu_rdata  out  DATA_W  fetch data
  lsu_req_valid  in  1  load/store request
  lsu_req_ready  out  1  load/store accepted this cycle
  lsu_addr  in  ADDR_W  load/store address
  lsu_wen  in  1  1 = store
  lsu_wdata  in  DATA_W  store data
  lsu_wmask  in  8  store byte mask
  lsu_resp_valid  out  1  one-cycle load/store response strobe
  lsu_rdata  out  DATA_W  load data (0 for stores)
  mem_ren  out  1  one-cycle read strobe
  mem_wen  out  1  one-cycle write strobe
  mem_addr  out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_wmask  out  8  memory write mask
  mem_resp_valid  in  1  memory done (read data valid / write acked)
  mem_rdata  in  DATA_W  memory read data

Function
REQ-005 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one outstanding access total.
REQ-006 Arbitration SHALL occur in IDLE and RESP: LSU wins over IFU unless starve counter == STARVE_MAX, then IFU wins.
REQ-007 Winner's *_req_ready SHALL be 1 combinationally in the arbitration cycle; loser's and all ready in ISSUE/WAIT SHALL be 0.
REQ-008 On handshake (valid&ready), addr/wen/wdata/wmask and owner SHALL be latched; next state ISSUE.
REQ-009 Starve counter SHALL increment (saturating at STARVE_MAX) when LSU granted while ifu_req_valid=1; clear to 0 when IFU granted.
REQ-010 In ISSUE, mem_ren (read) or mem_wen (LSU store) SHALL be 1 for exactly one cycle with latched addr/wdata/wmask; IFU accesses always reads.
REQ-011 mem_resp_valid SHALL be honoured in ISSUE or WAIT; if absent in ISSUE go WAIT, remain until it arrives (no timeout).
REQ-012 On mem_resp_valid, mem_rdata (0 for stores) SHALL be registered to owner's rdata; next state RESP.
REQ-013 In RESP, owner's *_resp_valid SHALL be 1 for exactly one cycle; rdata SHALL hold until next response.
REQ-014 mem_resp_valid in IDLE or RESP SHALL be ignored.
REQ-015 mem_addr/mem_wdata/mem_wmask SHALL hold last latched values outside ISSUE; strobes 0 outside ISSUE.
REQ-016 Latency, zero-wait memory: handshake cycle N, mem strobe N+1, resp_valid N+2; next handshake earliest N+2.
REQ-017 Requesters SHALL hold valid and payload stable until ready; block does not check this.

Reset
REQ-018 rst=1 SHALL immediately force IDLE, starve counter 0, all ready/strobe/resp_valid 0, rdata and mem_* buses 0.
REQ-019 Reset mid-access SHALL discard the access; no resp_valid issued for it; late mem_resp_valid ignored per REQ-014.

Structure
REQ-020 Shared package SHALL hold state enum (IDLE, ISSUE, WAIT, RESP), owner enum (OWN_IFU, OWN_LSU), and ADDR_W/DATA_W defaults.
REQ-021 One sub-module arb_pick SHALL implement combinational winner selection from both valids and starve count.

Verification
REQ-022 IFU only, addr 0x80000000, mem responds in ISSUE with 0x00100093 -> ifu_resp_valid at N+2, ifu_rdata=0x00100093.
REQ-023 Both valid at reset release, starve=0 -> LSU granted first; IFU granted at next arbitration after LSU completes.
REQ-024 LSU and IFU valid continuously -> LSU wins 4 times, 5th grant IFU, counter returns 0, pattern repeats.
REQ-025 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xFF -> mem_wen one cycle with those values, lsu_resp_valid, lsu_rdata=0.
REQ-026 mem_resp_valid delayed 3 cycles -> FSM holds WAIT, ready stays 0, single resp_valid after.
REQ-027 rst asserted in WAIT, then mem_resp_valid pulsed -> no resp_valid, FSM IDLE, outputs 0.
